// File: rtl/mips_cpu_instr_memory.sv
// Instruction memory and fetch monitor for the Harvard MIPS core.
// Optional fetch counter built only when IMEM_FETCH_COUNT_EN is defined.
module mips_cpu_instr_memory #(
    parameter int          ADDR_W = 10,
    parameter logic [31:0] BASE   = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        load_err,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    localparam int          DEPTH = 1 << ADDR_W;
    localparam logic [31:0] SPAN  = 32'(DEPTH) << 2;

    typedef enum logic [1:0] {
        S_LOAD,
        S_RUN,
        S_HALT
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [31:0] mem [DEPTH];

    logic [31:0] fetch_off;
    logic [31:0] load_off;
    logic        fetch_ok;
    logic        load_ok;
    logic        fetch_zero;
    logic        at_base;
    logic        mem_we;
    logic        err_d;
    logic        halted_d;
    logic        fault_d;

    // Unsigned wrap-around makes addresses below BASE land far out of range.
    assign fetch_off  = instr_address - BASE;
    assign load_off   = load_addr - BASE;
    assign fetch_ok   = (fetch_off < SPAN) && (instr_address[1:0] == 2'b00);
    assign load_ok    = (load_off < SPAN) && (load_addr[1:0] == 2'b00);
    assign fetch_zero = (instr_address == 32'h0);
    assign at_base    = (instr_address == BASE);

    assign instr_readdata = fetch_ok ? mem[fetch_off[ADDR_W+1:2]] : 32'h0;
    assign load_ready     = (state == S_LOAD);

    always_comb begin
        state_d  = state;
        mem_we   = 1'b0;
        err_d    = load_err;
        halted_d = halted;
        fault_d  = fault;
        if (clk_enable) begin
            err_d = 1'b0;
            case (state)
                S_LOAD: begin
                    if (load_valid) begin
                        if (load_ok) mem_we = 1'b1;
                        else         err_d  = 1'b1;
                    end else if (at_base) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    err_d = load_valid;
                    if (fetch_zero) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else if (!fetch_ok) begin
                        fault_d = 1'b1;
                    end
                end
                S_HALT: begin
                    err_d = load_valid;
                end
                default: begin
                    state_d = S_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_LOAD;
            load_err <= 1'b0;
            halted   <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_d;
            load_err <= err_d;
            halted   <= halted_d;
            fault    <= fault_d;
        end
    end

    // Storage has no reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (reset && mem_we) mem[load_off[ADDR_W+1:2]] <= load_data;
    end

`ifdef IMEM_FETCH_COUNT_EN
    logic        cnt_inc;
    logic [31:0] cnt;

    // The LOAD->RUN edge samples BASE and is the first counted fetch.
    assign cnt_inc = clk_enable &&
        ((state == S_LOAD && !load_valid && at_base) ||
         (state == S_RUN && !fetch_zero));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= 32'h0;
        end else if (cnt_inc && cnt != 32'hFFFFFFFF) begin
            cnt <= cnt + 32'h1;
        end
    end

    assign fetch_count = cnt;
`else
    assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_mips_cpu_instr_memory.sv
// Scoreboard bench for mips_cpu_instr_memory: expectations queued with
// stimulus, drained and compared once the DUT has responded.
module tb_mips_cpu_instr_memory;

    localparam logic [31:0] BASE = 32'hBFC00000;

    localparam int S_RD  = 0;
    localparam int S_RDY = 1;
    localparam int S_ERR = 2;
    localparam int S_HLT = 3;
    localparam int S_FLT = 4;
    localparam int S_CNT = 5;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        load_err;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          n_total;
    int          n_pass;
    logic [31:0] words [4];

    mips_cpu_instr_memory #(.ADDR_W(10), .BASE(BASE)) dut (
        .clk           (clk),
        .reset         (reset),
        .clk_enable    (clk_enable),
        .instr_address (instr_address),
        .instr_readdata(instr_readdata),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .load_err      (load_err),
        .halted        (halted),
        .fault         (fault),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] cnt_exp(input logic [31:0] n);
`ifdef IMEM_FETCH_COUNT_EN
        return n;
`else
        return 32'h0 & n;
`endif
    endfunction

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            S_RD:    return instr_readdata;
            S_RDY:   return {31'h0, load_ready};
            S_ERR:   return {31'h0, load_err};
            S_HLT:   return {31'h0, halted};
            S_FLT:   return {31'h0, fault};
            default: return fetch_count;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic push(input string tag, input int sig,
                        input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sig), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic status(input string t, input logic rdy, input logic err,
                          input logic hlt, input logic flt,
                          input logic [31:0] cnt);
        push({t, ".rdy"}, S_RDY, {31'h0, rdy});
        push({t, ".err"}, S_ERR, {31'h0, err});
        push({t, ".hlt"}, S_HLT, {31'h0, hlt});
        push({t, ".flt"}, S_FLT, {31'h0, flt});
        push({t, ".cnt"}, S_CNT, cnt_exp(cnt));
    endtask

    initial begin
        n_total       = 0;
        n_pass        = 0;
        words[0]      = 32'h24846006;
        words[1]      = 32'h00041082;
        words[2]      = 32'h00000008;
        words[3]      = 32'h24000000;
        reset         = 1'b0;
        clk_enable    = 1'b1;
        instr_address = 32'h0;
        load_valid    = 1'b0;
        load_addr     = 32'h0;
        load_data     = 32'h0;

        #12;
        status("reset", 1, 0, 0, 0, 0);
        drain();
        reset = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_addr  = BASE + 32'(4 * i);
            load_data  = words[i];
            tick();
        end
        load_valid = 1'b0;
        tick();
        status("loaded", 1, 0, 0, 0, 0);
        drain();

        for (int i = 0; i < 5; i++) begin
            instr_address = BASE + 32'(4 * i);
            push($sformatf("rd%0d", i), S_RD, (i < 4) ? words[i] : 32'h0);
            drain();
        end
        instr_address = 32'h0;

        load_valid = 1'b1;
        load_addr  = BASE + 32'h2;
        load_data  = 32'hDEADBEEF;
        tick();
        status("mis_load", 1, 1, 0, 0, 0);
        drain();
        load_addr = BASE - 32'h4;
        tick();
        status("low_load", 1, 1, 0, 0, 0);
        drain();
        load_valid = 1'b0;
        tick();
        push("err_clear", S_ERR, 32'h0);
        instr_address = BASE;
        push("w0_kept", S_RD, words[0]);
        drain();

        // A pending load holds LOAD even with BASE on the fetch bus.
        load_valid = 1'b1;
        load_addr  = BASE + 32'hC;
        load_data  = words[3];
        tick();
        status("blocked", 1, 0, 0, 0, 0);
        drain();
        load_valid = 1'b0;
        tick();
        status("to_run", 0, 0, 0, 0, 1);
        drain();

        instr_address = BASE + 32'h4;
        tick();
        instr_address = BASE + 32'h8;
        tick();
        push("rd_b8", S_RD, words[2]);
        status("run3", 0, 0, 0, 0, 3);
        drain();

        clk_enable    = 1'b0;
        load_valid    = 1'b1;
        load_addr     = BASE;
        load_data     = 32'hFFFFFFFF;
        instr_address = BASE + 32'h4;
        for (int i = 0; i < 5; i++) begin
            tick();
            status($sformatf("frz%0d", i), 0, 0, 0, 0, 3);
            drain();
        end

        clk_enable    = 1'b1;
        instr_address = BASE + 32'hC;
        tick();
        status("rej_run", 0, 1, 0, 0, 4);
        drain();
        load_valid = 1'b0;
        tick();
        status("rej_done", 0, 0, 0, 0, 5);
        instr_address = BASE;
        push("w0_run", S_RD, words[0]);
        drain();
        tick();
        push("cnt6", S_CNT, cnt_exp(6));
        drain();

        load_valid = 1'b1;
        tick();
        push("err7", S_ERR, 32'h1);
        drain();
        clk_enable = 1'b0;
        load_valid = 1'b0;
        tick();
        status("err_hold", 0, 1, 0, 0, 7);
        drain();
        clk_enable = 1'b1;
        tick();
        status("err_drop", 0, 0, 0, 0, 8);
        drain();

        instr_address = BASE + 32'h1000;
        push("rd_oor", S_RD, 32'h0);
        drain();
        tick();
        status("fault", 0, 0, 0, 1, 9);
        drain();

        instr_address = 32'h0;
        tick();
        status("halt", 0, 0, 1, 1, 9);
        drain();
        instr_address = BASE + 32'h4;
        tick();
        status("halt_hold", 0, 0, 1, 1, 9);
        drain();
        load_valid = 1'b1;
        load_addr  = BASE;
        tick();
        status("halt_rej", 0, 1, 1, 1, 9);
        drain();
        load_valid = 1'b0;

        #2;
        reset = 1'b0;
        status("rst_mid", 1, 0, 0, 0, 0);
        push("w1_kept", S_RD, words[1]);
        drain();
        reset = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mips_cpu_instr_memory.md
# mips_cpu_instr_memory

Instruction-side responder for the Harvard MIPS core: answers the CPU's fetch address with the stored word, mapped at the reset vector. Contents are written through a valid/ready load port before execution starts; the first fetch of the reset vector locks the memory. Also monitors the fetch stream: counts fetches, detects the halt fetch of address 0, and flags bad fetch addresses. Sits between the testbench/boot loader and the `instr_address`/`instr_readdata` pins of `mips_cpu_harvard`.

## Interface
- `ADDR_W`, 10: word-address width; depth = 2^ADDR_W words.
- `BASE`, 32'hBFC00000: byte address of word 0 (reset vector).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `clk_enable` in 1: when low, all state holds (loads and fetch monitoring frozen).
- `instr_address` in 32: CPU fetch byte address.
- `instr_readdata` out 32: fetched word, combinational from address and storage.
- `load_valid` in 1, `load_ready` out 1: load handshake.
- `load_addr` in 32, `load_data` in 32: load byte address and word.
- `load_err` out 1: one-cycle pulse on rejected load.
- `halted` out 1: sticky, halt fetch seen.
- `fault` out 1: sticky, bad fetch address seen in RUN.
- `fetch_count` out 32: enabled RUN cycles (see Configuration).

## Operation
- In range: `BASE <= a < BASE + 4*2^ADDR_W`; index = `(a - BASE) >> 2`, 32-bit unsigned subtraction.
- Read: `instr_readdata` = mem[index] if `instr_address` is in range and `[1:0]==0`; otherwise 32'h0 (NOP). Valid in every state.
- States: LOAD (after reset), RUN, HALTED.
- LOAD: `load_ready`=1. Transfer when `load_valid && load_ready` at an enabled edge.
  - In-range, aligned `load_addr`: mem[index] <= `load_data`.
  - Out-of-range or misaligned: no write; `load_err`=1 the following cycle.
  - LOAD->RUN at an enabled edge with `load_valid`=0 and `instr_address`==BASE. A pending load blocks the transition.
- RUN: `load_ready`=0. A `load_valid` at an enabled edge is rejected: `load_err` pulses, no write.
  - Each enabled edge with `instr_address` != 0: `fetch_count`+1, saturating at 32'hFFFFFFFF.
  - Same edge, address out of range or misaligned: `fault`<=1; count still increments.
  - Enabled edge with `instr_address`==0: ->HALTED, `halted`<=1, not counted, `fault` unchanged.
- HALTED: no counting; loads rejected as in RUN. Exit only by reset.
- Reset (any time, including mid-load or mid-run):
  - State LOAD; `load_ready`=1; `load_err`, `halted`, `fault`, `fetch_count` = 0.
  - Memory contents retained; power-up contents undefined.

## Timing
- Fetch latency 0: `instr_readdata` follows `instr_address` and storage combinationally. A word loaded at edge N is readable after edge N.
- `load_ready` is a function of state only; never depends on `load_valid`.
- `load_err`: registered, high exactly one cycle after the rejecting edge.
- `halted`, `fault`, `fetch_count`: registered, updated at the enabled edge that samples the address.
- The LOAD->RUN edge counts as fetch 1.
- `clk_enable`=0: no writes, no state change, no counting; `load_err` holds its previous value.

## Configuration
- `IMEM_FETCH_COUNT_EN` defined: `fetch_count` counter implemented as described.
- Not defined: `fetch_count` tied to 32'h0, no counter flops. State machine, `halted` and `fault` are unaffected.

## Test plan
- Load 4 words at BASE..BASE+12 (32'h24846006, 32'h00041082, 32'h00000008, 32'h24000000); drive `instr_address` BASE+4 -> `instr_readdata`=32'h00041082; BASE+16 -> 32'h0.
- Load to `load_addr`=BASE+2 and to BASE-4 -> `load_err` pulses each cycle after; mem unchanged; `load_ready` stays 1.
- Fetch BASE, BASE+4, BASE+8, then 0 -> state RUN, `fetch_count`=3, `halted`=1; further fetches leave count at 3.
- In RUN, assert `load_valid` with `load_addr`=BASE, `load_data`=32'hFFFFFFFF -> `load_err` pulse; word 0 still 32'h24846006.
- In RUN, fetch BASE+32'h1000 (ADDR_W=10) -> `fault`=1, `instr_readdata`=0, count increments. Pull `reset` low mid-run -> all outputs 0, `load_ready`=1, word 1 still 32'h00041082.
- `clk_enable`=0 for 5 cycles during RUN -> `fetch_count` frozen. Without `IMEM_FETCH_COUNT_EN`, `fetch_count` stays 0 throughout.
